// File: rtl/fetch_decode_skid.sv
// Two-entry skid buffer carrying fetch bundles from the IFU to decode, with redirect flush and stall counting.
// Latency: 1 cycle from an accepted bundle to out_* when the buffer is empty, or when it holds one entry that pops that cycle.
// Backpressure: in_ready is a registered decode of occupancy, so it absorbs at most one extra bundle after decode stalls.
module fetch_decode_skid #(
    parameter int FETCH_WIDTH = 4,
    parameter int PAYLOAD_W   = 256,
    parameter int FSQ_IDX_W   = 4,
    parameter int CNT_W       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [FETCH_WIDTH-1:0]             in_en,
    input  logic [FSQ_IDX_W-1:0]               in_fsq_idx,
    input  logic [PAYLOAD_W-1:0]               in_payload,
    input  logic                               redirect,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FETCH_WIDTH-1:0]             out_en,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]   out_num,
    output logic [FSQ_IDX_W-1:0]               out_fsq_idx,
    output logic [PAYLOAD_W-1:0]               out_payload,
    output logic [CNT_W-1:0]                   stall_cnt
);
    localparam int NUM_W = $clog2(FETCH_WIDTH + 1);

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] en;
        logic [FSQ_IDX_W-1:0]   fsq_idx;
        logic [PAYLOAD_W-1:0]   payload;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    entry_t            head_q, skid_q, in_entry;
    logic [CNT_W-1:0]  stall_q;
    logic [NUM_W-1:0]  num;
    logic              push, pop, head_we, skid_we, shift;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    // Empty-mask bundles still handshake but never enter the buffer.
    assign push = in_valid & in_ready & (|in_en) & ~redirect;
    assign pop  = out_valid & out_ready;

    assign in_entry.en      = in_en;
    assign in_entry.fsq_idx = in_fsq_idx;
    assign in_entry.payload = in_payload;

    always_comb begin
        state_d = state_q;
        head_we = 1'b0;
        skid_we = 1'b0;
        shift   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_we = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_we = 1'b1;
                end else if (push) begin
                    state_d = TWO;
                    skid_we = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    shift   = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any pop that lands in the same cycle.
        if (redirect) begin
            state_d = EMPTY;
            shift   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (head_we) begin
                head_q <= in_entry;
            end else if (shift) begin
                head_q <= skid_q;
            end
            if (skid_we) begin
                skid_q <= in_entry;
            end
            if (out_valid && !out_ready && !redirect && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        num = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            num = num + NUM_W'(head_q.en[i]);
        end
    end

    assign out_en      = head_q.en;
    assign out_num     = num;
    assign out_fsq_idx = head_q.fsq_idx;
    assign out_payload = head_q.payload;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_fetch_decode_skid.sv
// Bench for fetch_decode_skid: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fetch_decode_skid;
    localparam int FW     = 4;
    localparam int PW     = 64;
    localparam int IW     = 4;
    localparam int CW     = 8;
    localparam int NW     = $clog2(FW + 1);
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_en;
    logic [IW-1:0] in_fsq_idx;
    logic [PW-1:0] in_payload;
    logic          redirect;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_en;
    logic [NW-1:0] out_num;
    logic [IW-1:0] out_fsq_idx;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] stall_cnt;

    fetch_decode_skid #(
        .FETCH_WIDTH(FW), .PAYLOAD_W(PW), .FSQ_IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_en(in_en),
        .in_fsq_idx(in_fsq_idx), .in_payload(in_payload), .redirect(redirect),
        .out_valid(out_valid), .out_ready(out_ready), .out_en(out_en),
        .out_num(out_num), .out_fsq_idx(out_fsq_idx), .out_payload(out_payload),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of at most two bundles plus a saturating counter.
    typedef struct {
        logic [FW-1:0] en;
        logic [IW-1:0] idx;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t        mq[$];
    int unsigned mstall;
    bit          m_rdy, m_vld, m_push, m_pop;
    bit          cmp_on = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mstall = 0;
        end else begin
            m_rdy  = (mq.size() < 2);
            m_vld  = (mq.size() > 0);
            m_push = in_valid && m_rdy && (in_en != 0) && !redirect;
            m_pop  = m_vld && out_ready;
            if (m_vld && !out_ready && !redirect && mstall < CNTMAX) mstall++;
            if (redirect) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back('{en: in_en, idx: in_fsq_idx, pl: in_payload});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("stall_cnt", 64'(stall_cnt), 64'(mstall));
            if (mq.size() > 0) begin
                check("out_en", 64'(out_en), 64'(mq[0].en));
                check("out_num", 64'(out_num), 64'($countones(mq[0].en)));
                check("out_fsq_idx", 64'(out_fsq_idx), 64'(mq[0].idx));
                check("out_payload", 64'(out_payload), 64'(mq[0].pl));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [FW-1:0] en, input logic [IW-1:0] idx,
                         input logic rd, input logic ordy);
        in_valid   = v;
        in_en      = en;
        in_fsq_idx = idx;
        in_payload = {$urandom, $urandom};
        redirect   = rd;
        out_ready  = ordy;
    endtask

    int          next_idx;
    logic [IW-1:0] seen[$];

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        in_payload = '0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_en", 64'(out_en), 64'd0);
        check("rst_out_num", 64'(out_num), 64'd0);
        check("rst_out_fsq_idx", 64'(out_fsq_idx), 64'd0);
        check("rst_out_payload", out_payload, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        #6;
        rst = 1'b1;
        cmp_on = 1'b1;

        // Single bundle
        drive(1'b1, 4'b1011, 4'd3, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_num", 64'(out_num), 64'd3);
        check("single_idx", 64'(out_fsq_idx), 64'd3);
        step();
        check("single_drain", 64'(out_valid), 64'd0);

        // Backpressure: IFU streams 0,1,2 holding each until accepted; decode stalls cycles 1..3
        next_idx = 0;
        seen.delete();
        for (int c = 0; c < 8; c++) begin
            drive(next_idx < 3, 4'hF, IW'(next_idx), 1'b0, !(c >= 1 && c <= 3));
            if (out_valid && out_ready) seen.push_back(out_fsq_idx);
            if (in_valid && in_ready) next_idx++;
            step();
            if (c == 1) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_head", 64'(out_fsq_idx), 64'd0);
            end
        end
        check("bp_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++) check("bp_order", 64'(seen[i]), 64'(i));
        check("bp_stall", 64'(stall_cnt), 64'd3);

        // Empty mask is swallowed
        drive(1'b1, 4'b0000, 4'd5, 1'b0, 1'b0);
        step();
        check("empty_in_ready", 64'(in_ready), 64'd1);
        check("empty_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 4'b0001, 4'd6, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("empty_next_num", 64'(out_num), 64'd1);
        check("empty_next_idx", 64'(out_fsq_idx), 64'd6);
        step();

        // Redirect while full, with input and pop in the same cycle
        drive(1'b1, 4'hF, 4'd7, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'hF, 4'd8, 1'b0, 1'b0);
        step();
        check("redir_full", 64'(in_ready), 64'd0);
        drive(1'b1, 4'hF, 4'd9, 1'b1, 1'b1);
        step();
        check("redir_in_ready", 64'(in_ready), 64'd1);
        check("redir_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 4'b0110, 4'd10, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("redir_next_idx", 64'(out_fsq_idx), 64'd10);
        check("redir_stall", 64'(stall_cnt), 64'd4);
        step();

        // Simultaneous push and pop in ONE
        drive(1'b1, 4'hF, 4'd11, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b1100, 4'd12, 1'b0, 1'b1);
        step();
        check("pp_valid", 64'(out_valid), 64'd1);
        check("pp_head", 64'(out_fsq_idx), 64'd12);
        check("pp_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? FW'(0) : FW'($urandom_range(1, 15)),
                  IW'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            step();
        end

        // Saturation
        drive(1'b1, 4'hF, 4'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) step();
        check("sat_stall", 64'(stall_cnt), 64'(CNTMAX));

        // Asynchronous reset between edges while full
        drive(1'b1, 4'hF, 4'd2, 1'b0, 1'b0);
        step();
        check("ar_full", 64'(in_ready), 64'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_en", 64'(out_en), 64'd0);
        check("ar_out_fsq_idx", 64'(out_fsq_idx), 64'd0);
        check("ar_out_payload", out_payload, 64'd0);
        check("ar_stall", 64'(stall_cnt), 64'd0);
        #2;
        rst = 1'b1;
        drive(1'b1, 4'b0111, 4'd13, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("ar_first_valid", 64'(out_valid), 64'd1);
        check("ar_first_idx", 64'(out_fsq_idx), 64'd13);
        check("ar_first_num", 64'(out_num), 64'd3);

        for (int c = 0; c < 200; c++) begin
            drive($urandom_range(0, 1) != 0, FW'($urandom), IW'($urandom),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
            step();
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
